// File: rtl/word_ser_pkg.sv
`default_nettype none
// ============================================================================
// Module      : word_ser_pkg
// Description : Shared types and sizing helpers for the word serializer.
//               The WORD_SER_PARITY_EN macro adds one even-parity beat per word.
// Revision    : 1.0 - initial release
// ============================================================================
package word_ser_pkg;

    // Two-state control: waiting for a word, or shifting one out.
    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

`ifdef WORD_SER_PARITY_EN
    localparam int c_PARITY_BEATS = 1;
`else
    localparam int c_PARITY_BEATS = 0;
`endif

    // Beat counter width; WIDTH+1 values so the parity beat index fits too.
    function automatic int count_w(input int width);
        return $clog2(width + 1);
    endfunction

    // Serial beats per word (data bits plus optional parity beat).
    function automatic int nbeats(input int width);
        return width + c_PARITY_BEATS;
    endfunction

endpackage
`default_nettype wire

// File: rtl/shift_reg.sv
`default_nettype none
// ============================================================================
// Module      : shift_reg
// Description : WIDTH-bit parallel-load shift register with a shift-by-one
//               enable. LSB_FIRST selects which end is presented on o_bit.
// Revision    : 1.0 - initial release
// ============================================================================
module shift_reg #(
    parameter int WIDTH     = 16,
    parameter bit LSB_FIRST = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic             i_shift,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_bit
);

    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] w_shifted;

    generate
        if (LSB_FIRST) begin : g_lsb_first
            assign w_shifted = {1'b0, r_q[WIDTH-1:1]};
            assign o_bit     = r_q[0];
        end else begin : g_msb_first
            assign w_shifted = {r_q[WIDTH-2:0], 1'b0};
            assign o_bit     = r_q[WIDTH-1];
        end
    endgenerate

    // Load has priority so a new word can replace the drained one on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= '0;
        end else if (i_load) begin
            r_q <= i_data;
        end else if (i_shift) begin
            r_q <= w_shifted;
        end
    end

endmodule
`default_nettype wire

// File: rtl/word_serializer.sv
`default_nettype none
// ============================================================================
// Module      : word_serializer
// Description : Parallel-to-serial unloader. Accepts one WIDTH-bit word per
//               valid/ready handshake and emits it one bit per accepted beat,
//               with back-to-back reload on the final beat.
//               Optional macro WORD_SER_PARITY_EN appends an even-parity beat.
// Revision    : 1.0 - initial release
// ============================================================================
module word_serializer
    import word_ser_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter bit LSB_FIRST = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_bit,
    output logic             out_last,
    output logic             busy
);

    localparam int c_NBEATS  = nbeats(WIDTH);
    localparam int c_COUNT_W = count_w(WIDTH);
    localparam logic [c_COUNT_W-1:0] c_LAST_BEAT = c_COUNT_W'(c_NBEATS - 1);

    state_t                 r_state;
    state_t                 w_next_state;
    logic [c_COUNT_W-1:0]   r_count;
    logic                   w_beat;
    logic                   w_last;
    logic                   w_last_beat;
    logic                   w_accept;
    logic                   w_sr_bit;

    assign w_last      = (r_state == SHIFT) && (r_count == c_LAST_BEAT);
    assign w_beat      = (r_state == SHIFT) && out_ready;
    assign w_last_beat = w_beat && w_last;
    // Ready on the final beat too, so the next word follows with no bubble.
    assign in_ready    = (r_state == IDLE) || w_last_beat;
    assign w_accept    = in_valid && in_ready;

    assign out_valid   = (r_state == SHIFT);
    assign out_last    = w_last;
    assign busy        = (r_state != IDLE);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next state: start on acceptance, stay in SHIFT when a reload coincides with the last beat.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_next_state = SHIFT;
                end
            end
            SHIFT: begin
                if (w_last_beat && !w_accept) begin
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    // Beat counter: restarts on each new word, advances on every accepted beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (w_accept) begin
            r_count <= '0;
        end else if (w_beat) begin
            r_count <= r_count + c_COUNT_W'(1);
        end
    end

    shift_reg #(
        .WIDTH     (WIDTH),
        .LSB_FIRST (LSB_FIRST)
    ) u_shift_reg (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_load  (w_accept),
        .i_shift (w_beat && !w_accept),
        .i_data  (in_data),
        .o_bit   (w_sr_bit)
    );

`ifdef WORD_SER_PARITY_EN
    localparam logic [c_COUNT_W-1:0] c_PARITY_BEAT = c_COUNT_W'(WIDTH);

    logic r_parity;

    // Even parity of the accepted word, presented on the beat after the data bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_parity <= 1'b0;
        end else if (w_accept) begin
            r_parity <= ^in_data;
        end
    end

    assign out_bit = out_valid && ((r_count == c_PARITY_BEAT) ? r_parity : w_sr_bit);
`else
    assign out_bit = out_valid && w_sr_bit;
`endif

endmodule
`default_nettype wire
